uart_buffered: RTL and testbench
================================

UART_BUFFERED -- requirements
Module: uart_buffered

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports `clk` and `rst`.
REQ-002 Parameter CLK_DIV, default 434, SHALL give the clk cycles per bit (50 MHz / 115200); legal range 4..65535.
REQ-003 Parameter DATA_BITS, default 8, SHALL give the data bits per frame; legal range 5..9.
REQ-004 Parameter FIFO_AW, default 4, SHALL give the log2 depth of each FIFO, so each FIFO holds 2^FIFO_AW entries.
REQ-005 Parameter STOP_BITS, default 1, SHALL give the stop bits transmitted; legal values 1 or 2. RX checks only the first stop bit.
REQ-006 Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tx_data  in  DATA_BITS  byte to enqueue
- tx_wr  in  1  enqueue strobe
- tx_full  out  1  TX FIFO full
- tx_busy  out  1  TX FIFO non-empty or frame in progress
- rx_data  out  DATA_BITS  head of RX FIFO (show-ahead)
- rx_rd  in  1  dequeue strobe
- rx_empty  out  1  RX FIFO empty
- rx_overflow  out  1  sticky: a received byte was dropped
- rx_frame_err  out  1  one-cycle pulse: bad stop bit
- rx_parity_err  out  1  one-cycle pulse: parity mismatch
- TX  out  1  serial line out, idle high
- RX  in  1  asynchronous serial line in

Function
REQ-007 On a cycle with tx_wr=1 and tx_full=0, the TX FIFO SHALL store tx_data. A write while full SHALL be ignored with no state change.
REQ-008 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP. The FSM SHALL hold each bit for exactly CLK_DIV cycles and send data LSB first.
REQ-009 In IDLE with the TX FIFO non-empty, the TX FSM SHALL pop the head and drive TX low on the next cycle.
REQ-010 TX transitions SHALL be: START->DATA; DATA->PARITY when parity is compiled in, otherwise DATA->STOP; STOP->IDLE after STOP_BITS bit times.
REQ-011 Back-to-back frames SHALL have no idle gap beyond the single IDLE cycle.
REQ-012 tx_busy SHALL be 1 whenever the TX FIFO is non-empty or the TX FSM is not in IDLE.
REQ-013 RX SHALL pass through a 2-flop synchronizer. The RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-014 In RX IDLE, a synchronized falling edge SHALL enter START. After CLK_DIV/2 cycles (integer division), a sample of 1 SHALL return to IDLE as a false start with no output. Subsequent bits SHALL be sampled every CLK_DIV cycles.
REQ-015 If the stop-bit sample is 0, the block SHALL discard the byte and pulse rx_frame_err for one cycle. The RX FSM SHALL then wait in IDLE for the line to return high before re-arming.
REQ-016 A valid byte SHALL be pushed to the RX FIFO in the cycle after the stop-bit sample.
REQ-017 If a valid byte arrives while the RX FIFO is full and no pop occurs that cycle, the byte SHALL be dropped and rx_overflow set.
REQ-018 rx_overflow SHALL clear on the first successful pop.
REQ-019 A simultaneous push and pop while full SHALL both succeed, with no overflow.
REQ-020 On a cycle with rx_rd=1 and rx_empty=0, the RX FIFO SHALL pop, and rx_data SHALL show the new head on the next cycle. rx_rd while empty SHALL be ignored.
REQ-021 rx_data SHALL be forced to 0 while rx_empty=1.
REQ-022 Each FIFO SHALL use FIFO_AW-bit wrapping pointers plus a (FIFO_AW+1)-bit count. Full SHALL mean count = 2^FIFO_AW; empty SHALL mean count = 0.

Reset
REQ-023 rst SHALL apply on the clock edge, and SHALL abort any frame in progress, including a mid-frame TX (TX returns high next cycle).
REQ-024 rst SHALL empty both FIFOs.
REQ-025 Output values after reset SHALL be: TX=1, tx_full=0, tx_busy=0, rx_empty=1, rx_data=0, rx_overflow=0, rx_frame_err=0, rx_parity_err=0.
REQ-026 FIFO storage arrays need not be cleared by reset.

Configuration
REQ-027 With macro UART_PARITY_EN defined:
- parameter PARITY_ODD (default 0) SHALL select even (0) or odd (1) parity;
- a parity bit SHALL follow the data bits on TX and be checked on RX;
- an RX parity mismatch SHALL discard the byte and pulse rx_parity_err for one cycle.
REQ-028 Without UART_PARITY_EN, frames SHALL carry no parity bit, the PARITY states SHALL be unreachable, and rx_parity_err SHALL be tied to 0.

Verification
REQ-029 Loopback: with CLK_DIV=16, TX tied to RX, write 0xA5 -> rx_empty falls, rx_data=0xA5, 160 cycles per frame (no parity), TX low for exactly 16 cycles at the start bit.
REQ-030 TX full: with FIFO_AW=2, write 5 bytes in 5 consecutive cycles -> after the 4 writes at cycles 1-4, tx_full=1 on cycle 5, when the TX FSM has not yet popped, so the 5th write (cycle 5) is dropped. The TX line carries exactly bytes 1-4 in order, and tx_busy falls one cycle after the last stop bit.
REQ-031 RX overflow: with FIFO_AW=2, receive 5 frames 0x01-0x05 without reading -> rx_overflow=1, and reads return 0x01-0x04. rx_overflow clears on the first read.
REQ-032 Error frames: drive a frame with stop bit 0 -> one-cycle rx_frame_err pulse and rx_empty stays 1. Drive a 4-cycle low glitch -> no event.
REQ-033 Parity (UART_PARITY_EN, PARITY_ODD=0): send 0x07 -> parity bit 1, frame 176 cycles. Inject a corrupted parity bit -> rx_parity_err pulse and the byte is not enqueued.
REQ-034 Reset mid-frame: assert rst during DATA bit 3 -> TX=1 and tx_busy=0 on the next cycle. A subsequent write of 0x3C transmits cleanly.

Source files
------------

// File: rtl/uart_buffered.sv
// Buffered UART: TX/RX FIFOs around 8N1-style serial framing.
// Optional parity bit enabled by defining UART_PARITY_EN.
module uart_buffered #(
    parameter int CLK_DIV   = 434,
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 4,
    parameter int STOP_BITS = 1
`ifdef UART_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_wr,
    output logic                 tx_full,
    output logic                 tx_busy,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_rd,
    output logic                 rx_empty,
    output logic                 rx_overflow,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 TX,
    input  logic                 RX
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
    localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
    localparam logic [3:0]  LAST_DB = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_SB = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    logic [DATA_BITS-1:0] r_txf_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_txf_wp, r_txf_rp;
    logic [FIFO_AW:0]     r_txf_cnt;
    logic                 w_tx_push, w_tx_pop;
    logic [DATA_BITS-1:0] w_tx_head;

    state_t               r_tx_st;
    logic [15:0]          r_tx_cnt;
    logic [3:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_sh;
    logic                 r_tx;
`ifdef UART_PARITY_EN
    logic                 r_tx_par;
`endif

    assign tx_full   = (r_txf_cnt == FULL_CNT);
    assign w_tx_push = tx_wr && !tx_full;
    assign w_tx_pop  = (r_tx_st == S_IDLE) && (r_txf_cnt != '0);
    assign w_tx_head = r_txf_mem[r_txf_rp];
    assign tx_busy   = (r_txf_cnt != '0) || (r_tx_st != S_IDLE);
    assign TX        = r_tx;

    always_ff @(posedge clk) begin
        if (w_tx_push) r_txf_mem[r_txf_wp] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_txf_wp  <= '0;
            r_txf_rp  <= '0;
            r_txf_cnt <= '0;
        end else begin
            if (w_tx_push) r_txf_wp <= r_txf_wp + 1'b1;
            if (w_tx_pop)  r_txf_rp <= r_txf_rp + 1'b1;
            if (w_tx_push && !w_tx_pop)      r_txf_cnt <= r_txf_cnt + 1'b1;
            else if (!w_tx_push && w_tx_pop) r_txf_cnt <= r_txf_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_st  <= S_IDLE;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
            r_tx     <= 1'b1;
`ifdef UART_PARITY_EN
            r_tx_par <= 1'b0;
`endif
        end else begin
            case (r_tx_st)
                S_IDLE: begin
                    r_tx     <= 1'b1;
                    r_tx_cnt <= '0;
                    if (w_tx_pop) begin
                        r_tx_sh <= w_tx_head;
                        r_tx    <= 1'b0;
                        r_tx_st <= S_START;
`ifdef UART_PARITY_EN
                        r_tx_par <= (^w_tx_head) ^ (PARITY_ODD != 0);
`endif
                    end
                end
                S_START: begin
                    if (r_tx_cnt == DIV_M1) begin
                        r_tx_cnt <= '0;
                        r_tx_bit <= '0;
                        r_tx     <= r_tx_sh[0];
                        r_tx_st  <= S_DATA;
                    end else r_tx_cnt <= r_tx_cnt + 1'b1;
                end
                S_DATA: begin
                    if (r_tx_cnt == DIV_M1) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == LAST_DB) begin
                            r_tx_bit <= '0;
`ifdef UART_PARITY_EN
                            r_tx    <= r_tx_par;
                            r_tx_st <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_tx_st <= S_STOP;
`endif
                        end else begin
                            r_tx_bit <= r_tx_bit + 1'b1;
                            r_tx_sh  <= r_tx_sh >> 1;
                            r_tx     <= r_tx_sh[1];
                        end
                    end else r_tx_cnt <= r_tx_cnt + 1'b1;
                end
                S_PARITY: begin
                    if (r_tx_cnt == DIV_M1) begin
                        r_tx_cnt <= '0;
                        r_tx     <= 1'b1;
                        r_tx_st  <= S_STOP;
                    end else r_tx_cnt <= r_tx_cnt + 1'b1;
                end
                S_STOP: begin
                    if (r_tx_cnt == DIV_M1) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == LAST_SB) r_tx_st <= S_IDLE;
                        else r_tx_bit <= r_tx_bit + 1'b1;
                    end else r_tx_cnt <= r_tx_cnt + 1'b1;
                end
                default: r_tx_st <= S_IDLE;
            endcase
        end
    end

    logic                 r_rx_s1, r_rx_s2, r_rx_s3;
    state_t               r_rx_st;
    logic [15:0]          r_rx_cnt;
    logic [3:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_sh;
    logic                 r_rx_push, r_rx_ferr;
`ifdef UART_PARITY_EN
    logic                 r_rx_pbad, r_rx_perr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= RX;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    // Edge detect in IDLE also holds off re-arming while the line stays low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_st   <= S_IDLE;
            r_rx_cnt  <= '0;
            r_rx_bit  <= '0;
            r_rx_sh   <= '0;
            r_rx_push <= 1'b0;
            r_rx_ferr <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_pbad <= 1'b0;
            r_rx_perr <= 1'b0;
`endif
        end else begin
            r_rx_push <= 1'b0;
            r_rx_ferr <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_perr <= 1'b0;
`endif
            case (r_rx_st)
                S_IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_rx_s3 && !r_rx_s2) r_rx_st <= S_START;
                end
                S_START: begin
                    if (r_rx_cnt == HALF_M1) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_st  <= r_rx_s2 ? S_IDLE : S_DATA;
                    end else r_rx_cnt <= r_rx_cnt + 1'b1;
                end
                S_DATA: begin
                    if (r_rx_cnt == DIV_M1) begin
                        r_rx_cnt <= '0;
                        r_rx_sh  <= {r_rx_s2, r_rx_sh[DATA_BITS-1:1]};
                        if (r_rx_bit == LAST_DB) begin
                            r_rx_bit <= '0;
`ifdef UART_PARITY_EN
                            r_rx_st <= S_PARITY;
`else
                            r_rx_st <= S_STOP;
`endif
                        end else r_rx_bit <= r_rx_bit + 1'b1;
                    end else r_rx_cnt <= r_rx_cnt + 1'b1;
                end
                S_PARITY: begin
                    if (r_rx_cnt == DIV_M1) begin
                        r_rx_cnt <= '0;
                        r_rx_st  <= S_STOP;
`ifdef UART_PARITY_EN
                        r_rx_pbad <= r_rx_s2 ^ (^r_rx_sh) ^ (PARITY_ODD != 0);
`endif
                    end else r_rx_cnt <= r_rx_cnt + 1'b1;
                end
                S_STOP: begin
                    if (r_rx_cnt == DIV_M1) begin
                        r_rx_cnt <= '0;
                        r_rx_st  <= S_IDLE;
                        if (!r_rx_s2) r_rx_ferr <= 1'b1;
`ifdef UART_PARITY_EN
                        else if (r_rx_pbad) r_rx_perr <= 1'b1;
`endif
                        else r_rx_push <= 1'b1;
                    end else r_rx_cnt <= r_rx_cnt + 1'b1;
                end
                default: r_rx_st <= S_IDLE;
            endcase
        end
    end

    logic [DATA_BITS-1:0] r_rxf_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_rxf_wp, r_rxf_rp;
    logic [FIFO_AW:0]     r_rxf_cnt;
    logic                 r_rx_ovf;
    logic                 w_rx_full, w_rx_pop, w_rx_wr;

    assign rx_empty  = (r_rxf_cnt == '0);
    assign w_rx_full = (r_rxf_cnt == FULL_CNT);
    assign w_rx_pop  = rx_rd && !rx_empty;
    assign w_rx_wr   = r_rx_push && (!w_rx_full || w_rx_pop);
    assign rx_data   = rx_empty ? '0 : r_rxf_mem[r_rxf_rp];
    assign rx_overflow  = r_rx_ovf;
    assign rx_frame_err = r_rx_ferr;
`ifdef UART_PARITY_EN
    assign rx_parity_err = r_rx_perr;
`else
    assign rx_parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_rx_wr) r_rxf_mem[r_rxf_wp] <= r_rx_sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxf_wp  <= '0;
            r_rxf_rp  <= '0;
            r_rxf_cnt <= '0;
            r_rx_ovf  <= 1'b0;
        end else begin
            if (w_rx_wr)  r_rxf_wp <= r_rxf_wp + 1'b1;
            if (w_rx_pop) r_rxf_rp <= r_rxf_rp + 1'b1;
            if (w_rx_wr && !w_rx_pop)      r_rxf_cnt <= r_rxf_cnt + 1'b1;
            else if (!w_rx_wr && w_rx_pop) r_rxf_cnt <= r_rxf_cnt - 1'b1;
            if (w_rx_pop) r_rx_ovf <= 1'b0;
            else if (r_rx_push && w_rx_full) r_rx_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_buffered.sv
// Bench for uart_buffered: directed frame table, loopback corners
// and a randomized loopback stream checked against a byte queue.
module tb_uart_buffered;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_wr = 1'b0;
    logic       rx_rd = 1'b0;
    logic       tx_full, tx_busy, rx_empty, rx_overflow;
    logic       rx_frame_err, rx_parity_err, TX;
    logic [7:0] rx_data;
    logic       rx_drv = 1'b1;
    logic       loop = 1'b0;
    logic       w_rx;
`ifdef UART_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    assign w_rx = loop ? TX : rx_drv;

    always #5 clk = ~clk;

    uart_buffered #(
        .CLK_DIV(DIV), .DATA_BITS(8), .FIFO_AW(2), .STOP_BITS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_full(tx_full), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_rd(rx_rd),
        .rx_empty(rx_empty), .rx_overflow(rx_overflow),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
        .TX(TX), .RX(w_rx)
    );

    int total = 0, bad = 0;
    int cyc = 0, ferr_cnt = 0, perr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rx_frame_err)  ferr_cnt <= ferr_cnt + 1;
        if (rx_parity_err) perr_cnt <= perr_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic write(input logic [7:0] d);
        tx_data = d;
        tx_wr = 1'b1;
        tick();
        tx_wr = 1'b0;
    endtask

    task automatic pop();
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        rx_drv = b;
        wait_n(DIV);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop);
        rx_drv = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         glitch;
        logic       store;
        int         ferr;
    } vec_t;

    vec_t vt[6];
    int first_low, low_run, busy_fall, got_idx, t_w, f0, nsent;
    logic [7:0] got, d;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp5[5];

    initial begin
        vt[0] = '{8'h3C, 1'b1, 0, 1'b1, 0};
        vt[1] = '{8'h00, 1'b1, 0, 1'b1, 0};
        vt[2] = '{8'hFF, 1'b1, 0, 1'b1, 0};
        vt[3] = '{8'h5A, 1'b0, 0, 1'b0, 1};
        vt[4] = '{8'h00, 1'b1, 4, 1'b0, 0};
        vt[5] = '{8'h81, 1'b1, 0, 1'b1, 0};
        exp5  = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24};

        rst = 1'b1;
        wait_n(2);
        chk("rst_tx", TX, 1);
        chk("rst_full", tx_full, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_empty", rx_empty, 1);
        chk("rst_rxdata", rx_data, 0);
        chk("rst_ovf", rx_overflow, 0);
        chk("rst_ferr", rx_frame_err, 0);
        chk("rst_perr", rx_parity_err, 0);
        rst = 1'b0;
        tick();

        // Loopback single frame
        loop = 1'b1;
        write(8'hA5);
        first_low = -1; low_run = 0; busy_fall = -1; got_idx = -1; got = '0;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (TX == 1'b0 && first_low < 0) first_low = i;
            if (first_low > 0 && TX == 1'b0 && low_run == i - first_low)
                low_run++;
            if (busy_fall < 0 && !tx_busy) busy_fall = i;
            if (got_idx < 0 && !rx_empty) begin
                got_idx = i;
                got = rx_data;
            end
        end
        chk("lb_first_low", first_low, 1);
        chk("lb_start_len", low_run, DIV);
        chk("lb_frame_len", busy_fall - first_low, 10 * DIV);
        chk("lb_rx_seen", int'(got_idx > 0), 1);
        chk("lb_rx_data", got, 8'hA5);
        pop();
        chk("lb_empty_after", rx_empty, 1);
        chk("lb_zero_after", rx_data, 0);

        // TX FIFO fills behind an in-flight frame
        write(8'h11);
        t_w = cyc;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("full_before_wr%0d", k), tx_full, int'(k == 4));
            tx_data = 8'h21 + 8'(k);
            tx_wr = 1'b1;
            tick();
        end
        tx_wr = 1'b0;
        busy_fall = -1;
        got_q.delete();
        for (int i = 0; i < 1000; i++) begin
            rx_rd = 1'b0;
            if (!rx_empty) begin
                got_q.push_back(rx_data);
                rx_rd = 1'b1;
            end
            if (busy_fall < 0 && !tx_busy) busy_fall = cyc - t_w;
            tick();
        end
        rx_rd = 1'b0;
        chk("full_rx_count", got_q.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < got_q.size()) chk($sformatf("full_rx%0d", k), got_q[k], exp5[k]);
        chk("full_busy_fall", busy_fall, 4 * (10 * DIV + 1) + 10 * DIV + 1);

        // Reset during data bit 3
        write(8'h55);
        wait_n(70);
        rst = 1'b1;
        tick();
        chk("mid_rst_tx", TX, 1);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_empty", rx_empty, 1);
        rst = 1'b0;
        f0 = ferr_cnt;
        write(8'h3C);
        got_idx = -1;
        for (int i = 0; i < 400 && got_idx < 0; i++) begin
            tick();
            if (!rx_empty) got_idx = i;
        end
        chk("post_rst_seen", int'(got_idx >= 0), 1);
        chk("post_rst_data", rx_data, 8'h3C);
        chk("post_rst_ferr", ferr_cnt - f0, 0);
        if (!rx_empty) pop();

        // Directed RX frame table
        loop = 1'b0;
        rx_drv = 1'b1;
        wait_n(4);
        for (int v = 0; v < 6; v++) begin
            f0 = ferr_cnt;
            if (vt[v].glitch > 0) begin
                rx_drv = 1'b0;
                wait_n(vt[v].glitch);
                rx_drv = 1'b1;
            end else drive_frame(vt[v].d, vt[v].stop);
            wait_n(3 * DIV);
            chk($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vt[v].ferr);
            chk($sformatf("vec%0d_empty", v), rx_empty, int'(!vt[v].store));
            chk($sformatf("vec%0d_data", v), rx_data, vt[v].store ? vt[v].d : 8'h00);
            if (!rx_empty) pop();
        end

        // RX overflow
        for (int k = 1; k <= 5; k++) drive_frame(8'(k), 1'b1);
        wait_n(2 * DIV);
        chk("ovf_set", rx_overflow, 1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf_rd%0d", k), rx_data, k);
            pop();
            if (k == 1) chk("ovf_clear", rx_overflow, 0);
        end
        chk("ovf_drained", rx_empty, 1);

`ifdef UART_PARITY_EN
        loop = 1'b1;
        write(8'h07);
        busy_fall = -1;
        got = '0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 1 + DIV * 9 + DIV / 2) got[0] = TX;
            if (busy_fall < 0 && !tx_busy) busy_fall = i;
        end
        chk("par_bit", got[0], 1);
        chk("par_frame_len", busy_fall - 1, 11 * DIV);
        chk("par_rx_data", rx_data, 8'h07);
        if (!rx_empty) pop();
        loop = 1'b0;
        par_flip = 1'b1;
        f0 = perr_cnt;
        drive_frame(8'h07, 1'b1);
        wait_n(3 * DIV);
        chk("par_err_pulse", perr_cnt - f0, 1);
        chk("par_err_empty", rx_empty, 1);
        par_flip = 1'b0;
`endif

        // Randomized loopback stream against a byte queue
        loop = 1'b1;
        nsent = 0;
        exp_q.delete();
        for (int c = 0; c < 6000 && (nsent < 12 || exp_q.size() > 0); c++) begin
            tx_wr = 1'b0;
            rx_rd = 1'b0;
            if (nsent < 12 && !tx_full && $urandom_range(0, 7) == 0) begin
                d = 8'($urandom);
                tx_data = d;
                tx_wr = 1'b1;
                exp_q.push_back(d);
                nsent++;
            end
            if (!rx_empty && $urandom_range(0, 1) == 1) begin
                chk("rand_data", rx_data,
                    exp_q.size() > 0 ? int'(exp_q.pop_front()) : 32'h100);
                rx_rd = 1'b1;
            end
            tick();
        end
        tx_wr = 1'b0;
        rx_rd = 1'b0;
        chk("rand_pending", exp_q.size() + 12 - nsent, 0);
        chk("rand_no_ovf", rx_overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
